// File: rtl/adler32_stream.sv
`default_nettype none
// ============================================================================
// Module   : adler32_stream
// Function : Streaming Adler-32 checksum, LANES bytes per beat, one beat per
//            cycle. Result {B,A} is held until the consumer takes it.
//            Optional per-lane byte qualifier s_keep when ADLER32_KEEP_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module adler32_stream #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [8*LANES-1:0] s_data,
`ifdef ADLER32_KEEP_EN
  input  logic [LANES-1:0]   s_keep,
`endif
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [31:0]        m_checksum,
  output logic               busy
);

  localparam logic [16:0] MOD = 17'd65521;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           state_q;
  logic [15:0]      a_q, b_q;
  logic [15:0]      a_d, b_d;
  logic             busy_q;
  logic             s_ready_q;
  logic             m_valid_q;
  logic [LANES-1:0] lane_en;

`ifdef ADLER32_KEEP_EN
  assign lane_en = s_keep;
`else
  assign lane_en = '1;
`endif

  // Both operands are already reduced, so one conditional subtract suffices.
  function automatic logic [15:0] mod_add(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= MOD) begin
      sum = sum - MOD;
    end
    return sum[15:0];
  endfunction

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        a_d = mod_add(a_d, {8'h00, s_data[8*i +: 8]});
        b_d = mod_add(b_d, a_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      a_q       <= 16'h0001;
      b_q       <= 16'h0000;
      busy_q    <= 1'b0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (s_valid) begin
            a_q    <= a_d;
            b_q    <= b_d;
            busy_q <= 1'b1;
            if (s_last) begin
              state_q   <= ST_HOLD;
              s_ready_q <= 1'b0;
              m_valid_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            state_q   <= ST_ACCUM;
            a_q       <= 16'h0001;
            b_q       <= 16'h0000;
            busy_q    <= 1'b0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_ACCUM;
          s_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign busy       = busy_q;
  assign m_checksum = {b_q, a_q};

endmodule
`default_nettype wire

// File: tb/tb_adler32_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_adler32_stream
// Function : Self-checking bench for adler32_stream (LANES=1 and LANES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adler32_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s1_valid, s1_ready, s1_last, m1_valid, m1_ready, busy1;
  logic [7:0]  s1_data;
  logic [31:0] m1_ck;
  logic        s4_valid, s4_ready, s4_last, m4_valid, m4_ready, busy4;
  logic [31:0] s4_data;
  logic [3:0]  s4_keep;
  logic [31:0] m4_ck;

  adler32_stream #(.LANES(1)) u1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s1_valid),
    .s_ready    (s1_ready),
    .s_data     (s1_data),
`ifdef ADLER32_KEEP_EN
    .s_keep     (1'b1),
`endif
    .s_last     (s1_last),
    .m_valid    (m1_valid),
    .m_ready    (m1_ready),
    .m_checksum (m1_ck),
    .busy       (busy1)
  );

  adler32_stream #(.LANES(4)) u4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s4_valid),
    .s_ready    (s4_ready),
    .s_data     (s4_data),
`ifdef ADLER32_KEEP_EN
    .s_keep     (s4_keep),
`endif
    .s_last     (s4_last),
    .m_valid    (m4_valid),
    .m_ready    (m4_ready),
    .m_checksum (m4_ck),
    .busy       (busy4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Reference Adler-32: plain running sums modulo 65521.
  int unsigned ma, mb;
  task automatic mdl_clear();
    ma = 1;
    mb = 0;
  endtask
  task automatic mdl_byte(input logic [7:0] b);
    ma = (ma + int'(b)) % 65521;
    mb = (mb + ma) % 65521;
  endtask
  function automatic logic [31:0] mdl_sum();
    return {mb[15:0], ma[15:0]};
  endfunction

  logic [7:0]  fb[$];
  logic [31:0] bq[$];
  logic [3:0]  kq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input string nm, input int gap, input logic [31:0] exp);
    for (int i = 0; i < fb.size(); i++) begin
      int n;
      s1_valid = 1'b0;
      while ($urandom_range(0, 99) < gap) tick();
      s1_valid = 1'b1;
      s1_data  = fb[i];
      s1_last  = (i == fb.size() - 1);
      n = 0;
      while (!s1_ready && n < 100) begin tick(); n++; end
      if (!s1_ready) chk({nm, " ready timeout"}, 32'(s1_ready), 32'd1);
      tick();
      s1_valid = 1'b0;
      s1_last  = 1'b0;
      s1_data  = 8'($urandom);
      if (i == 0) chk({nm, " busy"}, 32'(busy1), 32'd1);
    end
    chk({nm, " m_valid"}, 32'(m1_valid), 32'd1);
    chk({nm, " checksum"}, m1_ck, exp);
    chk({nm, " s_ready hold"}, 32'(s1_ready), 32'd0);
  endtask

  task automatic drain1(input string nm, input int hold, input logic [31:0] exp);
    for (int k = 0; k < hold; k++) begin
      s1_valid = 1'b1;
      s1_last  = 1'b1;
      s1_data  = 8'($urandom);
      tick();
      chk({nm, " hold stable"}, m1_ck, exp);
      chk({nm, " hold s_ready"}, 32'(s1_ready), 32'd0);
    end
    s1_valid = 1'b0;
    s1_last  = 1'b0;
    m1_ready = 1'b1;
    tick();
    m1_ready = 1'b0;
    chk({nm, " released m_valid"}, 32'(m1_valid), 32'd0);
    chk({nm, " released s_ready"}, 32'(s1_ready), 32'd1);
    chk({nm, " released busy"}, 32'(busy1), 32'd0);
  endtask

  task automatic send4(input string nm, input int gap, input logic [31:0] exp);
    for (int i = 0; i < bq.size(); i++) begin
      int n;
      s4_valid = 1'b0;
      while ($urandom_range(0, 99) < gap) tick();
      s4_valid = 1'b1;
      s4_data  = bq[i];
      s4_keep  = kq[i];
      s4_last  = (i == bq.size() - 1);
      n = 0;
      while (!s4_ready && n < 100) begin tick(); n++; end
      if (!s4_ready) chk({nm, " ready timeout"}, 32'(s4_ready), 32'd1);
      tick();
      s4_valid = 1'b0;
      s4_last  = 1'b0;
      s4_data  = $urandom;
    end
    chk({nm, " m_valid"}, 32'(m4_valid), 32'd1);
    chk({nm, " checksum"}, m4_ck, exp);
    chk({nm, " A range"}, 32'(m4_ck[15:0] < 16'd65521), 32'd1);
    chk({nm, " B range"}, 32'(m4_ck[31:16] < 16'd65521), 32'd1);
    m4_ready = 1'b1;
    tick();
    m4_ready = 1'b0;
    chk({nm, " released m_valid"}, 32'(m4_valid), 32'd0);
    chk({nm, " released busy"}, 32'(busy4), 32'd0);
  endtask

  // Build a LANES=4 beat queue, feeding the model with kept bytes in lane order.
  task automatic add_beat4(input logic [31:0] d, input logic [3:0] k);
    bq.push_back(d);
    kq.push_back(k);
    for (int l = 0; l < 4; l++) begin
      if (k[l]) mdl_byte(d[8*l +: 8]);
    end
  endtask

  typedef struct {
    string       nm;
    logic [95:0] d;
    int          len;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{"abc",       96'h636261,                     3, 32'h024D0127};
    tbl[1] = '{"a",         96'h61,                         1, 32'h00620062};
    tbl[2] = '{"Wikipedia", 96'h61_69_64_65_70_69_6B_69_57, 9, 32'h11E60398};
    tbl[3] = '{"zero byte", 96'h00,                         1, 32'h00010001};
    tbl[4] = '{"ff ff",     96'hFF_FF,                      2, 32'h02FF01FF};

    rst_n = 1'b0;
    s1_valid = 1'b0; s1_last = 1'b0; s1_data = 8'h00; m1_ready = 1'b0;
    s4_valid = 1'b0; s4_last = 1'b0; s4_data = 32'h0; s4_keep = 4'hF; m4_ready = 1'b0;
    repeat (3) tick();
    chk("reset m_valid u1", 32'(m1_valid), 32'd0);
    chk("reset busy u1", 32'(busy1), 32'd0);
    chk("reset m_valid u4", 32'(m4_valid), 32'd0);
    chk("reset busy u4", 32'(busy4), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post-reset s_ready u1", 32'(s1_ready), 32'd1);
    chk("post-reset s_ready u4", 32'(s4_ready), 32'd1);
    chk("post-reset busy u1", 32'(busy1), 32'd0);

    // Table-driven LANES=1 frames with a 5-cycle m_ready stall each.
    for (int t = 0; t < 5; t++) begin
      logic [95:0] d;
      d = tbl[t].d;
      fb.delete();
      for (int i = 0; i < tbl[t].len; i++) fb.push_back(d[8*i +: 8]);
      send1(tbl[t].nm, 0, tbl[t].exp);
      drain1(tbl[t].nm, 5, tbl[t].exp);
    end

    // Reset mid-frame, then "abc" must start from a clean state.
    fb.delete();
    for (int i = 0; i < 3; i++) begin
      s1_valid = 1'b1; s1_data = 8'h10 + 8'(i); s1_last = 1'b0;
      tick();
    end
    s1_valid = 1'b0;
    chk("midframe busy before reset", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midframe reset busy", 32'(busy1), 32'd0);
    chk("midframe reset m_valid", 32'(m1_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midframe reset s_ready", 32'(s1_ready), 32'd1);
    fb = '{8'h61, 8'h62, 8'h63};
    send1("abc after reset", 0, 32'h024D0127);
    // Reset while holding a result drops it.
    rst_n = 1'b0;
    tick();
    chk("hold reset m_valid", 32'(m1_valid), 32'd0);
    chk("hold reset busy", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("hold reset s_ready", 32'(s1_ready), 32'd1);

    // Randomized LANES=1 frames with random s_valid gaps.
    for (int f = 0; f < 20; f++) begin
      int len;
      len = $urandom_range(1, 24);
      fb.delete();
      mdl_clear();
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        fb.push_back(b);
        mdl_byte(b);
      end
      send1("rand1", 30, mdl_sum());
      drain1("rand1", $urandom_range(0, 3), mdl_sum());
    end

`ifdef ADLER32_KEEP_EN
    bq.delete(); kq.delete(); mdl_clear();
    add_beat4(32'h696B6957, 4'hF);
    add_beat4(32'h69646570, 4'hF);
    add_beat4(32'hDEAD0061, 4'b0001);
    send4("Wikipedia x4 keep", 0, 32'h11E60398);
    bq.delete(); kq.delete(); mdl_clear();
    add_beat4($urandom, 4'b0000);
    send4("keep zero last", 0, 32'h00000001);
`endif

    // Randomized LANES=4 frames (random keep only when the port exists).
    for (int f = 0; f < 20; f++) begin
      int nb;
      nb = $urandom_range(1, 8);
      bq.delete(); kq.delete(); mdl_clear();
      for (int i = 0; i < nb; i++) begin
`ifdef ADLER32_KEEP_EN
        add_beat4($urandom, 4'($urandom));
`else
        add_beat4($urandom, 4'hF);
`endif
      end
      send4("rand4", 30, mdl_sum());
    end

    // 100000 bytes of 0xFF exercise many modular wraps of both sums.
    bq.delete(); kq.delete(); mdl_clear();
    for (int i = 0; i < 25000; i++) add_beat4(32'hFFFFFFFF, 4'hF);
    send4("ff 100000", 30, mdl_sum());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
